dmem_port_ctrl: RTL

Memory-stage controller between the EX stage and the word-indexed, 256-entry data memory (combinational read, write when `wen`, read and write mutually exclusive per cycle). It converts byte addresses to word indices and checks alignment and range. Stores go into a 2-entry store buffer that drains in cycles with no load; loads forward from that buffer. The result goes into the MEM/WB pipeline register.

---
 rtl/mem_pkg.sv | 19 +
 rtl/dmem_port_ctrl_store_buffer.sv | 88 ++++++++
 rtl/dmem_port_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage port controller.
// Store-buffer entries hold a word index plus the 32-bit store data.
package mem_pkg;

   localparam int IDX_W    = 8;
   localparam int SB_DEPTH = 2;

   typedef enum logic [1:0] {
      OP_ALU   = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [31:0]      data;
   } sb_entry_t;

endpackage

// File: rtl/dmem_port_ctrl_store_buffer.sv
// Circular store buffer with a parallel youngest-match lookup.
// Entries are pushed at the tail and drained from the head.
module store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  sb_entry_t        push_entry,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output sb_entry_t        head,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             hit,
   output logic [31:0]      hit_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;
   sb_entry_t        ent_q [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = ent_q[head_q];

   // Pointer and occupancy update; push and pop may coincide.
   always_comb begin
      head_d  = pop_ok ? ptr_inc(head_q) : head_q;
      tail_d  = push_ok ? ptr_inc(tail_q) : tail_q;
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Walk oldest to youngest so the youngest match wins.
   always_comb begin
      logic [PTR_W-1:0] p;
      hit      = 1'b0;
      hit_data = '0;
      p        = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < int'(count_q)) && (ent_q[p].idx == lookup_idx)) begin
            hit      = 1'b1;
            hit_data = ent_q[p].data;
         end
         p = ptr_inc(p);
      end
   end

   // Pointer registers; reset discards any buffered stores.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         ent_q[tail_q] <= push_entry;
      end
   end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Memory-stage controller: alignment/range checks, store buffering
// with load forwarding, drain arbitration and the MEM/WB register.
module dmem_port_ctrl
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int SB_DEPTH    = mem_pkg::SB_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_regwrite,
   input  logic        flush,
   output logic        out_valid,
   output logic        out_regwrite,
   output logic [4:0]  out_rd,
   output logic [31:0] out_data,
   output logic        out_exc,
   output logic [31:0] dmem_readaddr,
   output logic [31:0] dmem_waddr,
   output logic        dmem_wen,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata
);

   localparam int WIDX = $clog2(DEPTH_WORDS);

   op_e             op;
   logic [WIDX-1:0] idx;
   logic            is_mem;
   logic            misaligned;
   logic            out_of_range;
   logic            exc;
   logic            accept;
   logic            ld_acc;
   logic            st_push;
   logic            drain;

   logic            sb_full;
   logic            sb_empty;
   logic            sb_hit;
   logic [31:0]     sb_hit_data;
   sb_entry_t       sb_head;
   sb_entry_t       sb_new;

   logic            out_valid_q, out_valid_d;
   logic            out_regwrite_q, out_regwrite_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic [31:0]     out_data_q, out_data_d;
   logic            out_exc_q, out_exc_d;

   // Operation decode; loads take priority if both flags are set.
   always_comb begin
      unique case (1'b1)
         in_load:  op = OP_LOAD;
         in_store: op = OP_STORE;
         default:  op = OP_ALU;
      endcase
   end

   assign idx          = in_addr[WIDX+1:2];
   assign is_mem       = (op != OP_ALU);
   assign misaligned   = (in_addr[1:0] != 2'b00);
   assign out_of_range = (in_addr[31:WIDX+2] != '0);
   assign exc          = is_mem && (misaligned || out_of_range);

   assign in_ready = !(in_store && sb_full);
   assign accept   = in_valid && in_ready && !flush;
   assign ld_acc   = accept && (op == OP_LOAD) && !exc;
   assign st_push  = accept && (op == OP_STORE) && !exc;

   // Memory has one port per cycle: an accepted load blocks the drain.
   assign drain = !sb_empty && !ld_acc;

   assign sb_new = '{idx: IDX_W'(idx), data: in_wdata};

   store_buffer #(
      .DEPTH (SB_DEPTH)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .push       (st_push),
      .push_entry (sb_new),
      .pop        (drain),
      .full       (sb_full),
      .empty      (sb_empty),
      .head       (sb_head),
      .lookup_idx (IDX_W'(idx)),
      .hit        (sb_hit),
      .hit_data   (sb_hit_data)
   );

   assign dmem_readaddr = ld_acc ? 32'(idx) : '0;
   assign dmem_wen      = drain;
   assign dmem_waddr    = drain ? 32'(sb_head.idx) : '0;
   assign dmem_wdata    = drain ? sb_head.data : '0;

   // MEM/WB next state; excepting ops return zero data, no writeback.
   always_comb begin
      out_valid_d    = accept;
      out_regwrite_d = 1'b0;
      out_rd_d       = '0;
      out_data_d     = '0;
      out_exc_d      = 1'b0;
      if (accept) begin
         out_rd_d       = in_rd;
         out_exc_d      = exc;
         out_regwrite_d = in_regwrite && !exc;
         if (!exc) begin
            unique case (op)
               OP_LOAD:  out_data_d = sb_hit ? sb_hit_data : dmem_rdata;
               OP_STORE: out_data_d = '0;
               default:  out_data_d = in_addr;
            endcase
         end
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q    <= 1'b0;
         out_regwrite_q <= 1'b0;
         out_rd_q       <= '0;
         out_data_q     <= '0;
         out_exc_q      <= 1'b0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_regwrite_q <= out_regwrite_d;
         out_rd_q       <= out_rd_d;
         out_data_q     <= out_data_d;
         out_exc_q      <= out_exc_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_regwrite = out_regwrite_q;
   assign out_rd       = out_rd_q;
   assign out_data     = out_data_q;
   assign out_exc      = out_exc_q;

endmodule
